// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 32-bit ALU; logic/arith ops finish in one cycle, shifts iterate one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       control_line,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] acc, shifted, sum, diff, alu_r;
    logic [4:0]       cnt;
    logic             alu_ov, alu_il, is_shift;
    always_comb begin
        sum      = a + b;
        diff     = a - b;
        is_shift = control_line == 4'b1101 || control_line == 4'b1110;
        alu_r    = control_line == 4'b0000 ? a & b :
                   control_line == 4'b0001 ? a | b :
                   control_line == 4'b0010 ? sum :
                   control_line == 4'b0110 ? diff :
                   control_line == 4'b0111 ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
                   control_line == 4'b1100 ? ~(a | b) :
                   is_shift ? b : '0;
        alu_ov   = control_line == 4'b0010 ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                   control_line == 4'b0110 ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) :
                   1'b0;
        alu_il   = !(control_line inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110});
        shifted  = op == 4'b1101 ? acc << 1 : acc >> 1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    op <= control_line;
                    if (is_shift && shamt != 5'd0) begin
                        acc   <= b;
                        cnt   <= shamt;
                        state <= SHIFT;
                    end else begin
                        result   <= alu_r;
                        overflow <= alu_ov;
                        illegal  <= alu_il;
                        done     <= 1'b1;
                    end
                end
            end else begin
                acc <= shifted;
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    result   <= shifted;
                    overflow <= 1'b0;
                    illegal  <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
            end
        end
    end
    assign busy = state == SHIFT;
    assign zero = result == '0;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with a done-driven scoreboard checking results, flags and latency.
module tb_seq_alu;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]  control_line = '0;
    logic [31:0] a = '0, b = '0, result;
    logic [4:0]  shamt = '0;
    logic        zero, overflow, illegal, busy, done;
    int          n_cmp = 0, n_bad = 0, cyc = 0;

    typedef struct {
        logic [31:0] r;
        logic        ov;
        logic        il;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t m_e;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .control_line(control_line),
        .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero),
        .overflow(overflow), .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Drives one start pulse; the expected response is queued with its completion cycle.
    task automatic go(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [4:0] sh, input bit push, input logic [31:0] er,
                      input logic eo, input logic ei, input int lat);
        exp_t e;
        start = 1'b1; control_line = op; a = aa; b = bb; shamt = sh;
        e.r = er; e.ov = eo; e.il = ei; e.due = cyc + lat;
        if (push) q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                m_e = q.pop_front();
                chk("result", result, m_e.r);
                chk("zero", {31'd0, zero}, {31'd0, m_e.r == 32'd0});
                chk("overflow", {31'd0, overflow}, {31'd0, m_e.ov});
                chk("illegal", {31'd0, illegal}, {31'd0, m_e.il});
                chk("latency", cyc, m_e.due);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        settle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_ill", {31'd0, illegal}, 32'd0);

        go(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 1, 32'h80000000, 1, 0, 1);
        settle(2);
        go(4'b0110, 32'd5, 32'd5, 5'd0, 1, 32'h0, 0, 0, 1);
        go(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0, 1, 32'h1, 0, 0, 1);
        settle(2);
        go(4'b0001, 32'h0000000F, 32'h000000F0, 5'd0, 1, 32'h000000FF, 0, 0, 1);
        go(4'b1100, 32'h0, 32'h0, 5'd0, 1, 32'hFFFFFFFF, 0, 0, 1);
        go(4'b0110, 32'h80000000, 32'h1, 5'd0, 1, 32'h7FFFFFFF, 1, 0, 1);
        go(4'b0111, 32'h1, 32'hFFFFFFFF, 5'd0, 1, 32'h0, 0, 0, 1);
        go(4'b0010, 32'h1, 32'hFFFFFFFF, 5'd0, 1, 32'h0, 0, 0, 1);
        settle(2);

        go(4'b1101, 32'h0, 32'h1, 5'd31, 1, 32'h80000000, 0, 0, 32);
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            chk("shift_busy", {31'd0, busy}, 32'd1);
            chk("shift_zero_stable", {31'd0, zero}, 32'd1);
            if (i == 10) begin
                start = 1'b1; control_line = 4'b0000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
            end
            if (i == 11) start = 1'b0;
        end
        @(negedge clk);
        chk("shift_busy_end", {31'd0, busy}, 32'd0);
        settle(1);
        go(4'b1110, 32'h0, 32'h80000000, 5'd4, 1, 32'h08000000, 0, 0, 5);
        b = 32'h0; shamt = 5'd1;
        settle(6);

        go(4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1, 32'h0, 0, 1, 1);
        settle(2);
        go(4'b1101, 32'h0, 32'h00001234, 5'd0, 1, 32'h00001234, 0, 0, 1);
        settle(2);

        go(4'b1110, 32'h0, 32'hFFFFFFFF, 5'd10, 0, 32'h0, 0, 0, 11);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        go(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1, 32'hF000F000, 0, 0, 1);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        settle(2);
        chk("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle 32-bit ALU that executes the 4-bit `control_line` codes produced by the ALU control decoder. It sits in the EX stage between the register-file operand muxes and the write-back/branch logic. Logic and arithmetic ops complete in one cycle. Shifts run iteratively at one bit per cycle under a start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand/result width; must be 32 (shift count is 5 bits)
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: request; sampled only in IDLE
- `control_line` input 4: operation code (AND 0000, OR 0001, add 0010, sub 0110, slt 0111, NOR 1100, sll 1101, srl 1110)
- `a` input 32: operand A (rs)
- `b` input 32: operand B (rt / immediate); shifted operand for sll/srl
- `shamt` input 5: shift amount for sll/srl, ignored otherwise
- `result` output 32: registered result, held until next completion
- `zero` output 1: `result == 0`, combinational from the result register
- `overflow` output 1: registered signed overflow of add/sub, 0 for all other ops
- `illegal` output 1: registered; 1 when the completed op had an undefined code
- `busy` output 1: high while in SHIFT
- `done` output 1: one-cycle completion pulse

## Operation
- States: IDLE, SHIFT.
- IDLE with `start=1`: latch `control_line`.
  - Non-shift op, or shift with `shamt=0`: compute, load `result`/`overflow`/`illegal`, pulse `done`, stay IDLE.
  - Shift with `shamt!=0`: acc←`b`, cnt←`shamt`, go to SHIFT. Result flags are not updated yet.
- SHIFT, each edge:
  - acc shifts by 1: left for sll, logical right (zero fill) for srl. cnt←cnt−1.
  - When cnt==1 at the edge: `result`←shifted acc, `done`←1, `overflow`←0, `illegal`←0, return to IDLE.
- `start` while in SHIFT is ignored; it is not queued.
- Arithmetic:
  - add/sub wrap modulo 2^32.
  - `overflow` = operand signs equal (add) or differ (sub), and the result sign differs from `a`.
  - slt uses signed compare: result = 32'd1 if $signed(a) < $signed(b), else 32'd0.
  - NOR = ~(a|b).
- Undefined code (any value not listed): result←0, `illegal`←1, `overflow`←0, `done` pulses at single-cycle latency.
- Operands `a`, `b`, `shamt` are sampled only at the start edge. Changes during SHIFT have no effect.
- Reset (any state, including mid-shift): state←IDLE, result←0, overflow←0, illegal←0, done←0, cnt←0, acc←0. An aborted shift never produces `done`.

## Timing
- Reset values: `result`=0, `zero`=1, `overflow`=0, `illegal`=0, `busy`=0, `done`=0.
- Start accepted at edge E0 (end of cycle 0).
- Non-shift op, or shift with `shamt=0`: `done`=1 and new `result` valid in cycle 1. Latency is 1.
- Shift with `shamt=N` (1..31):
  - `busy`=1 in cycles 1..N.
  - `done`=1 with final `result` in cycle N+1; `busy`=0 in that cycle.
  - Latency is N+1.
- `done` is high for exactly one cycle per accepted start.
- Back-to-back: `start` in the same cycle `done` is high is accepted (the FSM is in IDLE).
- `start` held high continuously re-triggers on every IDLE cycle.
- `zero` tracks `result` in the same cycle. It is stable during SHIFT because `result` keeps its prior value until completion.
- `rst` takes priority over `start` on the same edge.

## Test plan
- Reset then idle → result=0, zero=1, busy=0, done=0.
- add a=0x7FFFFFFF, b=1 → cycle 1: done=1, result=0x80000000, overflow=1, zero=0.
- sub a=5, b=5, then slt a=0xFFFFFFFF, b=1 back-to-back → result=0/zero=1, then result=1, overflow=0, each with done in the cycle after its start.
- sll b=0x00000001, shamt=31 → busy high in cycles 1..31, done in cycle 32, result=0x80000000. Then srl b=0x80000000, shamt=4 → result=0x08000000 after 5 cycles. A start pulse mid-shift is ignored.
- control_line=4'b1111 → cycle 1: done=1, illegal=1, result=0. Then shift with shamt=0 → done in cycle 1, result=b, illegal=0.
- srl shamt=10, rst asserted at cycle 5 → next cycle: busy=0, result=0, no done pulse ever. A subsequent AND a=0xF0F0F0F0, b=0xFF00FF00 → result=0xF000F000.
